// File: rtl/tick_sched.sv
// Round-robin shared tick divider for two requesters (A = bit0, B = bit1).
// Optional abort support is enabled by defining TICK_SCHED_ABORT_EN.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; arbitrate on any request
// RUN    | owner holds the divider; ticks issued as divcnt reaches zero
// DONE   | one-cycle done pulse, grant dropped; may re-arbitrate at once
module tick_sched #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [DIV_W-1:0] div_a,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [DIV_W-1:0] div_b,
  input  logic [CNT_W-1:0] cnt_b,
`ifdef TICK_SCHED_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       gnt,
  output logic [1:0]       tick,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             kill;
  logic             fire;
  logic             arb_last;
  logic             win;
  logic [DIV_W-1:0] div_raw;
  logic [DIV_W-1:0] div_sel;
  logic [CNT_W-1:0] cnt_sel;

`ifdef TICK_SCHED_ABORT_EN
  logic abort_q, abort_d;
  assign kill    = abort && (state_q == S_RUN);
  assign aborted = (state_q == S_DONE) && abort_q;
`else
  assign kill = 1'b0;
`endif

  // In DONE the finishing owner already counts as "last" so the other port wins a tie.
  assign arb_last = (state_q == S_DONE) ? owner_q : last_q;
  assign win      = (req == 2'b11) ? ~arb_last : req[1];
  assign div_raw  = win ? div_b : div_a;
  assign div_sel  = (div_raw == '0) ? DIV_ONE : div_raw;
  assign cnt_sel  = win ? cnt_b : cnt_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      div_q    <= '0;
      divcnt_q <= '0;
      rem_q    <= '0;
      gnt_q    <= 2'b00;
`ifdef TICK_SCHED_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      div_q    <= div_d;
      divcnt_q <= divcnt_d;
      rem_q    <= rem_d;
      gnt_q    <= gnt_d;
`ifdef TICK_SCHED_ABORT_EN
      abort_q  <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    div_d    = div_q;
    divcnt_d = divcnt_q;
    rem_d    = rem_q;
    gnt_d    = gnt_q;
`ifdef TICK_SCHED_ABORT_EN
    abort_d  = abort_q;
`endif
    fire     = 1'b0;
    tick     = 2'b00;
    done     = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d  = S_RUN;
          owner_d  = win;
          div_d    = div_sel;
          divcnt_d = div_sel - DIV_ONE;
          rem_d    = cnt_sel;
          gnt_d    = win ? 2'b10 : 2'b01;
        end
      end

      S_RUN: begin
        fire = (divcnt_q == '0) && (rem_q != '0) && !kill;
        tick[owner_q] = fire;
        if (kill) begin
          state_d = S_DONE;
          gnt_d   = 2'b00;
`ifdef TICK_SCHED_ABORT_EN
          abort_d = 1'b1;
`endif
        end else begin
          if (fire) begin
            divcnt_d = div_q - DIV_ONE;
            rem_d    = rem_q - CNT_ONE;
          end else begin
            divcnt_d = divcnt_q - DIV_ONE;
          end
          // Leave on the edge that issues the last tick, so done lands in cnt*div + 1.
          if ((rem_q == '0) || (fire && (rem_q == CNT_ONE))) begin
            state_d = S_DONE;
            gnt_d   = 2'b00;
          end
        end
      end

      S_DONE: begin
        done[owner_q] = 1'b1;
        last_d        = owner_q;
`ifdef TICK_SCHED_ABORT_EN
        abort_d       = 1'b0;
`endif
        if (req != 2'b00) begin
          state_d  = S_RUN;
          owner_d  = win;
          div_d    = div_sel;
          divcnt_d = div_sel - DIV_ONE;
          rem_d    = cnt_sel;
          gnt_d    = win ? 2'b10 : 2'b01;
        end else begin
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;

endmodule
